// File: rtl/dram_sequencer_if.sv
// DRAM sequencer bus: decoded Z80 memory request in,
// RAS/CAS/MUX strobes and CPU wait request out.
interface dram_sequencer_if;
  logic mreq;
  logic rd;
  logic wr;
  logic rfsh;
  logic csdram;
  logic bank;
  logic ras1;
  logic ras2;
  logic cas1;
  logic cas2;
  logic mux;
  logic waitn;

  modport master (
    output mreq, rd, wr, rfsh, csdram, bank,
    input  ras1, ras2, cas1, cas2, mux, waitn
  );

  modport slave (
    input  mreq, rd, wr, rfsh, csdram, bank,
    output ras1, ras2, cas1, cas2, mux, waitn
  );
endinterface

// File: rtl/dram_sequencer.sv
// Clocked DRAM strobe generator: RAS/CAS/MUX sequencing with
// cycle-counted setup, hold and precharge, plus CPU wait request.
module dram_sequencer #(
  parameter int T_RM  = 1,
  parameter int T_MC  = 1,
  parameter int T_CAS = 2,
  parameter int T_REF = 3,
  parameter int T_RP  = 2
) (
  input logic       clk,
  input logic       resetn,
  dram_sequencer_if.slave bus
);

  // A timing value of 0 behaves like 1.
  localparam logic [3:0] L_RM =
    (T_RM <= 1) ? 4'd0 : 4'(T_RM - 1);
  localparam logic [3:0] L_MC =
    (T_MC <= 1) ? 4'd0 : 4'(T_MC - 1);
  localparam logic [3:0] L_CAS =
    (T_CAS <= 1) ? 4'd0 : 4'(T_CAS - 1);
  localparam logic [3:0] L_REF =
    (T_REF <= 1) ? 4'd0 : 4'(T_REF - 1);
  localparam logic [3:0] L_RP =
    (T_RP <= 1) ? 4'd0 : 4'(T_RP - 1);

  typedef enum logic [2:0] {
    IDLE, ROW, COL, CAS, REF, PRE
  } st_t;

  logic [5:0] s1;
  logic [5:0] s2;
  logic       smreq;
  logic       srd;
  logic       swr;
  logic       srfsh;
  logic       scs;
  logic       sbank;
  logic       refreq;
  logic       accreq;

  st_t        st;
  st_t        ns;
  logic [3:0] cnt;
  logic [3:0] ncnt;
  logic       bsel;
  logic       nbsel;
  logic       expd;

  logic [1:0] ras_d;
  logic [1:0] cas_d;
  logic       mux_d;
  logic       wait_d;
  logic [1:0] ras_q;
  logic [1:0] cas_q;
  logic       mux_q;
  logic       wait_q;

  assign smreq = s2[0];
  assign srd   = s2[1];
  assign swr   = s2[2];
  assign srfsh = s2[3];
  assign scs   = s2[4];
  assign sbank = s2[5];

  assign refreq = !smreq && !srfsh;
  assign accreq = !smreq && srfsh && !scs
               && (!srd || !swr);
  assign expd   = (cnt == 4'd0);

  always_comb begin
    ns    = st;
    nbsel = bsel;
    ncnt  = expd ? 4'd0 : cnt - 4'd1;
    case (st)
      IDLE: begin
        if (refreq) begin
          ns   = REF;
          ncnt = L_REF;
        end else if (accreq) begin
          ns    = ROW;
          ncnt  = L_RM;
          nbsel = sbank;
        end
      end
      ROW: begin
        if (smreq) begin
          ns   = PRE;
          ncnt = L_RP;
        end else if (expd) begin
          ns   = COL;
          ncnt = L_MC;
        end
      end
      COL: begin
        if (smreq) begin
          ns   = PRE;
          ncnt = L_RP;
        end else if (expd) begin
          ns   = CAS;
          ncnt = L_CAS;
        end
      end
      CAS, REF: begin
        if (expd && smreq) begin
          ns   = PRE;
          ncnt = L_RP;
        end
      end
      PRE: begin
        // Expiry passes through IDLE in the same edge so a
        // queued access sees exactly T_RP precharge cycles.
        if (expd) begin
          if (refreq) begin
            ns   = REF;
            ncnt = L_REF;
          end else if (accreq) begin
            ns    = ROW;
            ncnt  = L_RM;
            nbsel = sbank;
          end else begin
            ns   = IDLE;
            ncnt = 4'd0;
          end
        end
      end
      default: begin
        ns   = IDLE;
        ncnt = 4'd0;
      end
    endcase
  end

  always_comb begin
    ras_d  = 2'b11;
    cas_d  = 2'b11;
    mux_d  = 1'b1;
    wait_d = 1'b1;
    case (ns)
      ROW: begin
        ras_d[nbsel] = 1'b0;
        wait_d       = 1'b0;
      end
      COL: begin
        ras_d[nbsel] = 1'b0;
        mux_d        = 1'b0;
        wait_d       = 1'b0;
      end
      CAS: begin
        ras_d[nbsel] = 1'b0;
        cas_d[nbsel] = 1'b0;
        mux_d        = 1'b0;
      end
      REF: ras_d = 2'b00;
      PRE: wait_d = !accreq;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1     <= 6'h3f;
      s2     <= 6'h3f;
      st     <= IDLE;
      cnt    <= 4'd0;
      bsel   <= 1'b0;
      ras_q  <= 2'b11;
      cas_q  <= 2'b11;
      mux_q  <= 1'b1;
      wait_q <= 1'b1;
    end else begin
      s1     <= {bus.bank, bus.csdram, bus.rfsh,
                 bus.wr, bus.rd, bus.mreq};
      s2     <= s1;
      st     <= ns;
      cnt    <= ncnt;
      bsel   <= nbsel;
      ras_q  <= ras_d;
      cas_q  <= cas_d;
      mux_q  <= mux_d;
      wait_q <= wait_d;
    end
  end

  assign bus.ras1  = ras_q[0];
  assign bus.ras2  = ras_q[1];
  assign bus.cas1  = cas_q[0];
  assign bus.cas2  = cas_q[1];
  assign bus.mux   = mux_q;
  assign bus.waitn = wait_q;

endmodule

// File: tb/tb_dram_sequencer.sv
// Directed bench for dram_sequencer: output vector is
// {ras1, ras2, cas1, cas2, mux, waitn} sampled 1ns after each edge.
module tb_dram_sequencer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] ID    = 6'b111111;
  localparam logic [5:0] R1ROW = 6'b011110;
  localparam logic [5:0] R1COL = 6'b011100;
  localparam logic [5:0] R1CAS = 6'b010101;
  localparam logic [5:0] R2ROW = 6'b101110;
  localparam logic [5:0] R2COL = 6'b101100;
  localparam logic [5:0] R2CAS = 6'b101001;
  localparam logic [5:0] REFO  = 6'b001111;
  localparam logic [5:0] PREW  = 6'b111110;

  dram_sequencer_if bus();

  dram_sequencer #(
    .T_RM(1), .T_MC(1), .T_CAS(2),
    .T_REF(3), .T_RP(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {bus.ras1, bus.ras2, bus.cas1,
            bus.cas2, bus.mux, bus.waitn};
  endfunction

  task automatic check(input string tag,
                       input logic [5:0] got,
                       input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stepchk(input string tag,
                         input logic [5:0] exp);
    step();
    check(tag, outs(), exp);
  endtask

  task automatic drv(input logic m, input logic r,
                     input logic w, input logic f,
                     input logic c, input logic b);
    bus.mreq   = m;
    bus.rd     = r;
    bus.wr     = w;
    bus.rfsh   = f;
    bus.csdram = c;
    bus.bank   = b;
  endtask

  task automatic idle();
    drv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd0();
    drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic to_cas(input string tag);
    rd0();
    stepchk({tag, "_a0"}, ID);
    stepchk({tag, "_a1"}, ID);
    stepchk({tag, "_row"}, R1ROW);
    stepchk({tag, "_col"}, R1COL);
    stepchk({tag, "_cas"}, R1CAS);
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    repeat (3) step();
    check("rst", outs(), ID);
    resetn = 1'b1;
    stepchk("rst_rel", ID);

    // read, bank 1, held then released
    to_cas("rd");
    for (int i = 0; i < 5; i++) stepchk("rd_hold", R1CAS);
    idle();
    stepchk("rd_m0", R1CAS);
    stepchk("rd_m1", R1CAS);
    stepchk("rd_pre0", ID);
    stepchk("rd_pre1", ID);
    stepchk("rd_idle", ID);

    // write, bank 2, WR late, BANK flips mid-cycle
    drv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    stepchk("wr_m0", ID);
    stepchk("wr_m1", ID);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    stepchk("wr_w0", ID);
    stepchk("wr_w1", ID);
    stepchk("wr_row", R2ROW);
    stepchk("wr_col", R2COL);
    stepchk("wr_cas", R2CAS);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) stepchk("wr_bank", R2CAS);
    idle();
    stepchk("wr_m0", R2CAS);
    stepchk("wr_m1", R2CAS);
    for (int i = 0; i < 3; i++) stepchk("wr_end", ID);

    // refresh, request for one edge
    drv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.mreq = 1'b0;
    bus.rfsh = 1'b0;
    stepchk("rf_0", ID);
    idle();
    stepchk("rf_1", ID);
    for (int i = 0; i < 3; i++) stepchk("rf_ras", REFO);
    stepchk("rf_pre0", ID);
    stepchk("rf_pre1", ID);
    stepchk("rf_idle", ID);

    // back-to-back: next read queued during precharge
    to_cas("bb");
    idle();
    stepchk("bb_m0", R1CAS);
    rd0();
    stepchk("bb_m1", R1CAS);
    stepchk("bb_pre0", ID);
    stepchk("bb_pre1", PREW);
    stepchk("bb_row", R1ROW);
    stepchk("bb_col", R1COL);
    stepchk("bb_cas", R1CAS);
    idle();
    stepchk("bb_r0", R1CAS);
    stepchk("bb_r1", R1CAS);
    for (int i = 0; i < 3; i++) stepchk("bb_end", ID);

    // abort while in ROW
    rd0();
    stepchk("ab_0", ID);
    idle();
    stepchk("ab_1", ID);
    stepchk("ab_row", R1ROW);
    stepchk("ab_pre", ID);
    for (int i = 0; i < 4; i++) stepchk("ab_nocas", ID);

    // DRAM not selected
    drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) stepchk("cs_off", ID);
    idle();
    step();
    step();

    // reset in the middle of CAS
    to_cas("rm");
    resetn = 1'b0;
    stepchk("rm_rst", ID);
    idle();
    stepchk("rm_hold", ID);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) stepchk("rm_idle", ID);

    // normal read timing after the mid-cycle reset
    to_cas("ar");
    idle();
    stepchk("ar_m0", R1CAS);
    stepchk("ar_m1", R1CAS);
    stepchk("ar_pre", ID);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
